// File: rtl/minibyte_bus_ctrl_pkg.sv
// Shared types and width helpers for the Minibyte bus controller.
// Holds the FSM state enum, the decoded region enum and the index-width helper.
package minibyte_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        RG_RAM,
        RG_ROM,
        RG_EXT
    } region_t;

    // Wait-state counter width; WAIT_STATES is limited to 0..15.
    localparam int WAIT_W = 4;

    // Index width for a power-of-two depth, never narrower than one bit.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/minibyte_bus_ctrl_if.sv
// CPU request/ready bus between the Minibyte core and the bus controller.
// master: CPU side (drives request); slave: controller side (drives rdy/rdata).
interface minibyte_bus_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              cpu_req_in;
    logic              cpu_we_in;
    logic [ADDR_W-1:0] cpu_addr_in;
    logic [DATA_W-1:0] cpu_wdata_in;
    logic              cpu_rdy_out;
    logic [DATA_W-1:0] cpu_rdata_out;

    modport master (
        output cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
        input  cpu_rdy_out, cpu_rdata_out
    );

    modport slave (
        input  cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
        output cpu_rdy_out, cpu_rdata_out
    );
endinterface

// File: rtl/minibyte_bus_ctrl_reg_ram.sv
// Onboard register RAM: synchronous write, asynchronous read, sync clear.
// Ports: clk_in, rst_in, we_in, addr_in, wdata_in -> rdata_out.
module minibyte_reg_ram
    import minibyte_bus_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    localparam int AW    = addr_bits(DEPTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              we_in,
    input  logic [AW-1:0]     addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic [DATA_W-1:0] rdata_out
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we_in) begin
            mem[addr_in] <= wdata_in;
        end
    end

    assign rdata_out = mem[addr_in];
endmodule

// File: rtl/minibyte_bus_ctrl.sv
// Minibyte bus controller: decodes CPU requests into RAM, ROM or external bus.
// Ports: clk_in/rst_in, CPU bus (slave modport), mode bits, ROM port, ext bus, busy_out.
module minibyte_bus_ctrl
    import minibyte_bus_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int RAM_DEPTH   = 4,
    parameter int ROM_DEPTH   = 32,
    parameter int WAIT_STATES = 2,
    localparam int ROM_AW     = addr_bits(ROM_DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    minibyte_bus_ctrl_if.slave   bus,
    input  logic                 ram_en_in,
    input  logic                 rom_en_in,
    output logic [ROM_AW-1:0]    rom_addr_out,
    input  logic [DATA_W-1:0]    rom_data_in,
    output logic [ADDR_W-1:0]    ext_addr_out,
    output logic                 ext_we_out,
    output logic [DATA_W-1:0]    ext_wdata_out,
    output logic [DATA_W-1:0]    ext_oe_out,
    input  logic [DATA_W-1:0]    ext_rdata_in,
    output logic                 busy_out
);
    localparam int RAM_AW = addr_bits(RAM_DEPTH);
    localparam logic [ADDR_W:0] RAM_BASE =
        (ADDR_W+1)'((1 << ADDR_W) - RAM_DEPTH);

    state_t            state;
    region_t           region;
    logic [WAIT_W-1:0] cnt;
    logic              rdy_q;
    logic [DATA_W-1:0] rdata_q;
    logic              accept;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign rom_addr_out = bus.cpu_addr_in[ROM_AW-1:0];

    // RAM window sits at the top of the address space and beats the ROM.
    always_comb begin
        region = RG_EXT;
        if (ram_en_in && ({1'b0, bus.cpu_addr_in} >= RAM_BASE)) begin
            region = RG_RAM;
        end else if (rom_en_in) begin
            region = RG_ROM;
        end
    end

    assign accept = (state == ST_IDLE) && bus.cpu_req_in;
    assign ram_we = accept && (region == RG_RAM) && bus.cpu_we_in;

    minibyte_reg_ram #(
        .DEPTH  (RAM_DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .we_in     (ram_we),
        .addr_in   (bus.cpu_addr_in[RAM_AW-1:0]),
        .wdata_in  (bus.cpu_wdata_in),
        .rdata_out (ram_rdata)
    );

    // ext_we_out is only ever high while in EXT, so it doubles as the
    // drive-enable source for the data pins.
    assign ext_oe_out        = {DATA_W{ext_we_out}};
    assign bus.cpu_rdy_out   = rdy_q;
    assign bus.cpu_rdata_out = rdata_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            rdy_q         <= 1'b0;
            rdata_q       <= '0;
            ext_addr_out  <= '0;
            ext_wdata_out <= '0;
            ext_we_out    <= 1'b0;
            busy_out      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.cpu_req_in) begin
                        busy_out <= 1'b1;
                        unique case (region)
                            RG_RAM: begin
                                if (!bus.cpu_we_in) rdata_q <= ram_rdata;
                                rdy_q <= 1'b1;
                                state <= ST_RESP;
                            end
                            RG_ROM: begin
                                if (!bus.cpu_we_in) rdata_q <= rom_data_in;
                                rdy_q <= 1'b1;
                                state <= ST_RESP;
                            end
                            default: begin
                                ext_addr_out  <= bus.cpu_addr_in;
                                ext_wdata_out <= bus.cpu_wdata_in;
                                ext_we_out    <= bus.cpu_we_in;
                                cnt           <= WAIT_W'(WAIT_STATES);
                                state         <= ST_EXT;
                            end
                        endcase
                    end
                end
                ST_EXT: begin
                    if (cnt == '0) begin
                        if (!ext_we_out) rdata_q <= ext_rdata_in;
                        ext_we_out <= 1'b0;
                        rdy_q      <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt - WAIT_W'(1);
                    end
                end
                default: begin
                    rdy_q    <= 1'b0;
                    busy_out <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
